cs_seq_ctrl: RTL and testbench

CS_SEQ_CTRL -- requirements
Module: cs_seq_ctrl

---
 rtl/cs_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_cs_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cs_seq_ctrl.sv
// rtl/cs_seq_ctrl.sv - windowed approximate-average sequencer (optional CS_RUNSUM_EN running-sum build)
// An accepted sample shifts into an N-deep window. The block sums the window, then
// finds the largest sample not exceeding the mean. It reports (sum + N*near) >> 3.
// Define CS_RUNSUM_EN to keep the sum incrementally on accept and skip the SUM pass.
module cs_seq_ctrl #(
  parameter int N = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] X,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] Y,
  output logic       busy
);

  // idx must also reach N, which marks the finalize cycle at the end of SCAN
  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] CNT_N = IW'(N);
  localparam logic [3:0]    NW    = 4'(N);
`ifndef CS_RUNSUM_EN
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_SCAN, S_OUT} state_t;

  state_t        r_state;
  logic [7:0]    r_win [N];
  logic [11:0]   r_sum;
  logic [7:0]    r_near;
  logic [IW-1:0] r_idx;
  logic [9:0]    r_y;
  logic          r_out_valid;
  logic          r_busy;
  logic          r_in_ready;

  logic          w_accept;
  logic [7:0]    w_cur;
  logic [11:0]   w_prod;
  logic [12:0]   w_res;

  assign w_accept = in_valid & r_in_ready;
  // During the finalize cycle idx equals N and no window entry is read
  assign w_cur    = (r_idx < CNT_N) ? r_win[r_idx] : 8'd0;
  assign w_prod   = {8'd0, NW} * {4'd0, w_cur};
  assign w_res    = {1'b0, r_sum} + ({9'd0, NW} * {5'd0, r_near});

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Y         = r_y;
  assign busy      = r_busy;

  // Sequencer: window shift, sum pass, nearest-below-mean scan, result hand-off
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < N; i++) r_win[i] <= 8'd0;
      r_sum       <= 12'd0;
      r_near      <= 8'd0;
      r_idx       <= '0;
      r_y         <= 10'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            for (int i = N - 1; i > 0; i--) r_win[i] <= r_win[i-1];
            r_win[0]   <= X;
`ifdef CS_RUNSUM_EN
            // The window sum never drops below its oldest entry, so this cannot underflow
            r_sum      <= r_sum + {4'd0, X} - {4'd0, r_win[N-1]};
            r_near     <= 8'd0;
            r_state    <= S_SCAN;
`else
            r_sum      <= 12'd0;
            r_state    <= S_SUM;
`endif
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
`ifndef CS_RUNSUM_EN
        S_SUM: begin
          r_sum <= r_sum + {4'd0, w_cur};
          if (r_idx == LAST) begin
            r_idx   <= '0;
            r_near  <= 8'd0;
            r_state <= S_SCAN;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
`endif
        S_SCAN: begin
          if (r_idx == CNT_N) begin
            r_y         <= w_res[12:3];
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            if ((w_prod <= r_sum) && (w_cur > r_near)) r_near <= w_cur;
            r_idx <= r_idx + IW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_seq_ctrl.sv
// tb/tb_cs_seq_ctrl.sv - randomized self-checking bench for cs_seq_ctrl
module tb_cs_seq_ctrl;

  localparam int N = 9;
`ifdef CS_RUNSUM_EN
  localparam int LAT = N + 1;
`else
  localparam int LAT = 2 * N + 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] X;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] Y;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int mwin [N];

  always #5 clk = ~clk;

  cs_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .busy      (busy)
  );

  // Reference model: the mean-bounded maximum of the last N samples, combined with the window total
  function automatic int model_y();
    int s;
    int nr;
    s  = 0;
    nr = 0;
    foreach (mwin[i]) s += mwin[i];
    foreach (mwin[i]) if (mwin[i] * N <= s && mwin[i] > nr) nr = mwin[i];
    return (s + N * nr) / 8;
  endfunction

  task automatic model_push(input int x);
    for (int i = N - 1; i > 0; i--) mwin[i] = mwin[i-1];
    mwin[0] = x;
  endtask

  task automatic model_clear();
    foreach (mwin[i]) mwin[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // Accept one sample from IDLE, wait for the result, then consume it after hold stall cycles
  task automatic run_one(input int x, input int hold, output int y, output int lat);
    in_valid  = 1'b1;
    X         = 8'(x);
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_push(x);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    y = int'(Y);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    X        = 8'd200;
    do_reset();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (Y !== 10'd0) begin errors++; $display("FAIL rst_y got %0d want 0", Y); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_no_accept busy=%b in_ready=%b want 0/1", busy, in_ready);
    end
  endtask

  task automatic test_single();
    int y, lat;
    run_one(90, 0, y, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", lat, LAT); end
    checks++; if (y != 11) begin errors++; $display("FAIL single_y got %0d want 11", y); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL single_consumed ov=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
    end
    checks++; if (Y !== 10'd11) begin errors++; $display("FAIL single_y_hold got %0d want 11", Y); end
  endtask

  task automatic test_const(input int v, input int final_y);
    int y, lat;
    do_reset();
    for (int k = 0; k < N; k++) begin
      run_one(v, k % 3, y, lat);
      checks++; if (y != model_y()) begin errors++; $display("FAIL const%0d_step%0d got %0d want %0d", v, k, y, model_y()); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL const%0d_lat%0d got %0d want %0d", v, k, lat, LAT); end
    end
    checks++; if (y != final_y) begin errors++; $display("FAIL const%0d_final got %0d want %0d", v, y, final_y); end
  endtask

  task automatic test_backpressure();
    int yexp, lat, x;
    x = $urandom_range(0, 255);
    in_valid  = 1'b1;
    X         = 8'(x);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_push(x);
    yexp = model_y();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != LAT) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, LAT); end
    checks++; if (int'(Y) != yexp) begin errors++; $display("FAIL bp_y got %0d want %0d", Y, yexp); end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      X        = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || int'(Y) != yexp || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d ov=%b y=%0d in_ready=%b busy=%b want 1/%0d/0/1", k, out_valid, Y, in_ready, busy, yexp);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_consume ov=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_scan();
    int y, lat;
    bit leaked;
    in_valid  = 1'b1;
    X         = 8'($urandom_range(1, 255));
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef CS_RUNSUM_EN
    repeat (3) begin @(posedge clk); #1; end
`else
    repeat (N + 3) begin @(posedge clk); #1; end
`endif
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL scan_pre busy=%b ov=%b want 1/0", busy, out_valid);
    end
    in_valid = 1'b1;
    X        = 8'd77;
    do_reset();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || Y !== 10'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL scan_reset busy=%b ov=%b y=%0d in_ready=%b want 0/0/0/1", busy, out_valid, Y, in_ready);
    end
    leaked = 1'b0;
    repeat (LAT + 3) begin @(posedge clk); #1; if (out_valid !== 1'b0) leaked = 1'b1; end
    checks++; if (leaked) begin errors++; $display("FAIL scan_abort result emitted after reset, want none"); end
    run_one(90, 0, y, lat);
    checks++; if (y != 11) begin errors++; $display("FAIL scan_window_clear got %0d want 11", y); end
  endtask

  task automatic test_random();
    int y, lat;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      run_one($urandom_range(0, 255), $urandom_range(0, 3), y, lat);
      checks++; if (y != model_y()) begin errors++; $display("FAIL rand%0d_y got %0d want %0d", k, y, model_y()); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL rand%0d_lat got %0d want %0d", k, lat, LAT); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = 8'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_const(8, 18);
    test_const(255, 573);
    test_backpressure();
    test_reset_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
